// File: rtl/geofence.sv
// Point-in-convex-hexagon test: serially loads object + 6 anchor points, sorts the anchors CCW
// around AP1, then checks the object against all six edges. GEOFENCE_BOUNDARY_INSIDE_EN counts edge points as inside.
module geofence #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               valid,
    output logic               is_inside
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int CW = 2 * COORD_W + 3;

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_CHECK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         pos_q, pos_d;
    logic [2:0]         lim_q, lim_d;
    logic               all_pos_q, all_pos_d;
    logic               valid_q, valid_d;
    logic               is_inside_q, is_inside_d;
    logic [COORD_W-1:0] x_q [0:6];
    logic [COORD_W-1:0] x_d [0:6];
    logic [COORD_W-1:0] y_q [0:6];
    logic [COORD_W-1:0] y_d [0:6];

    logic [2:0]           sb_s;
    logic [2:0]           kb_s;
    logic signed [CW-1:0] cross_sort_s;
    logic signed [CW-1:0] cross_chk_s;
    logic                 edge_ok_s;

    function automatic logic signed [DW-1:0] diff_f(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        diff_f = $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [CW-1:0] cross_f(input logic signed [DW-1:0] ax,
                                                     input logic signed [DW-1:0] ay,
                                                     input logic signed [DW-1:0] bx,
                                                     input logic signed [DW-1:0] by);
        logic signed [PW-1:0] axw, ayw, bxw, byw;
        logic signed [CW-1:0] p1, p2;
        axw     = PW'(ax);
        ayw     = PW'(ay);
        bxw     = PW'(bx);
        byw     = PW'(by);
        p1      = CW'(axw * byw);
        p2      = CW'(ayw * bxw);
        cross_f = p1 - p2;
    endfunction

    assign sb_s = pos_q + 3'd1;
    assign kb_s = (idx_q == 3'd6) ? 3'd1 : idx_q + 3'd1;

    // Sorting is relative to AP1; the edge check is relative to the object.
    assign cross_sort_s = cross_f(diff_f(x_q[pos_q], x_q[3'd1]), diff_f(y_q[pos_q], y_q[3'd1]),
                                  diff_f(x_q[sb_s],  x_q[3'd1]), diff_f(y_q[sb_s],  y_q[3'd1]));
    assign cross_chk_s  = cross_f(diff_f(x_q[idx_q], x_q[3'd0]), diff_f(y_q[idx_q], y_q[3'd0]),
                                  diff_f(x_q[kb_s],  x_q[3'd0]), diff_f(y_q[kb_s],  y_q[3'd0]));

`ifdef GEOFENCE_BOUNDARY_INSIDE_EN
    assign edge_ok_s = ~cross_chk_s[CW-1];
`else
    assign edge_ok_s = ~cross_chk_s[CW-1] & (|cross_chk_s);
`endif

    // Next-state logic for load, bubble sort, edge check and result pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pos_d       = pos_q;
        lim_d       = lim_q;
        all_pos_d   = all_pos_q;
        valid_d     = 1'b0;
        is_inside_d = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        case (state_q)
            S_LOAD: begin
                x_d[idx_q] = X;
                y_d[idx_q] = Y;
                if (idx_q == 3'd6) begin
                    state_d = S_SORT;
                    pos_d   = 3'd2;
                    lim_d   = 3'd5;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_SORT: begin
                if (cross_sort_s[CW-1]) begin
                    x_d[pos_q] = x_q[sb_s];
                    y_d[pos_q] = y_q[sb_s];
                    x_d[sb_s]  = x_q[pos_q];
                    y_d[sb_s]  = y_q[pos_q];
                end else begin
                    x_d = x_q;
                    y_d = y_q;
                end
                if (pos_q == lim_q) begin
                    if (lim_q == 3'd2) begin
                        state_d   = S_CHECK;
                        idx_d     = 3'd1;
                        all_pos_d = 1'b1;
                    end else begin
                        lim_d = lim_q - 3'd1;
                        pos_d = 3'd2;
                    end
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end
            S_CHECK: begin
                all_pos_d = all_pos_q & edge_ok_s;
                if (idx_q == 3'd6) begin
                    state_d     = S_DONE;
                    idx_d       = 3'd0;
                    valid_d     = 1'b1;
                    is_inside_d = all_pos_q & edge_ok_s;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_LOAD;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, control and coordinate registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            idx_q       <= 3'd0;
            pos_q       <= 3'd2;
            lim_q       <= 3'd5;
            all_pos_q   <= 1'b0;
            valid_q     <= 1'b0;
            is_inside_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            lim_q       <= lim_d;
            all_pos_q   <= all_pos_d;
            valid_q     <= valid_d;
            is_inside_q <= is_inside_d;
        end
        x_q <= x_d;
        y_q <= y_d;
    end

    assign valid     = valid_q;
    assign is_inside = is_inside_q;

endmodule

// File: tb/tb_geofence.sv
// Self-checking bench for geofence: expected results come from an independent hull-edge
// model and are queued at stimulus time, then popped when a valid pulse appears.
module tb_geofence;

    localparam int TB_W = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [TB_W-1:0] X = '0;
    logic [TB_W-1:0] Y = '0;
    logic            valid;
    logic            is_inside;

    int vectors = 0;
    int miscompares = 0;
    int ax [6];
    int ay [6];
    bit exp_q [$];

    geofence #(.COORD_W(TB_W)) dut (
        .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside)
    );

    always #5 clk = ~clk;

    // Reference: O must lie on the hull side of every supporting line through two APs.
    function automatic bit ref_inside(input int ox, input int oy);
        bit ok;
        int c, co, neg;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (i != j) begin
                    neg = 0;
                    for (int k = 0; k < 6; k++) begin
                        if (k != i && k != j) begin
                            c = (ax[j] - ax[i]) * (ay[k] - ay[i]) - (ay[j] - ay[i]) * (ax[k] - ax[i]);
                            if (c < 0) neg++;
                        end
                    end
                    if (neg == 0) begin
                        co = (ax[j] - ax[i]) * (oy - ay[i]) - (ay[j] - ay[i]) * (ox - ax[i]);
`ifdef GEOFENCE_BOUNDARY_INSIDE_EN
                        if (co < 0) ok = 1'b0;
`else
                        if (co <= 0) ok = 1'b0;
`endif
                    end
                end
            end
        end
        return ok;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called on a negedge: drives O now, then AP1..AP6 on the following negedges.
    task automatic send_object(input int ox, input int oy);
        exp_q.push_back(ref_inside(ox, oy));
        X = TB_W'(ox);
        Y = TB_W'(oy);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            X = TB_W'(ax[i]);
            Y = TB_W'(ay[i]);
        end
    endtask

    task automatic wait_valid(input int budget, output bit got, output logic ins);
        got = 1'b0;
        ins = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                got = 1'b1;
                ins = is_inside;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", valid); miscompares++;
        end
        vectors++;
        if (is_inside !== 1'b0) begin
            $display("FAIL reset_is_inside: got %b want 0", is_inside); miscompares++;
        end
    endtask

    task automatic test_ccw_latency();
        bit exp;
        ax = '{100, 200, 250, 200, 100, 50};
        ay = '{0, 0, 100, 200, 200, 100};
        reset_dut();
        send_object(150, 100);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            vectors++;
            if (valid !== (n == 17)) begin
                $display("FAIL latency_valid n=%0d: got %b want %b", n, valid, (n == 17)); miscompares++;
            end
            if (n == 17 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                vectors++;
                if (is_inside !== exp || exp !== 1'b1) begin
                    $display("FAIL ccw_inside: got %b want %b", is_inside, exp); miscompares++;
                end
            end else if (n != 17) begin
                vectors++;
                if (is_inside !== 1'b0) begin
                    $display("FAIL idle_is_inside n=%0d: got %b want 0", n, is_inside); miscompares++;
                end
            end
        end
    endtask

    task automatic test_shuffled();
        int obx [2] = '{300, 150};
        int want [2] = '{0, 1};
        bit got, exp;
        logic ins;
        ax = '{200, 100, 50, 250, 100, 200};
        ay = '{200, 0, 100, 100, 200, 0};
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            send_object(obx[t], 100);
            wait_valid(30, got, ins);
            exp = exp_q.pop_front();
            vectors++;
            if (!got || ins !== exp || exp !== want[t][0]) begin
                $display("FAIL shuffled_%0d: got valid=%b inside=%b want inside=%b", t, got, ins, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_boundary();
        bit got, exp;
        logic ins;
        ax = '{100, 200, 250, 200, 100, 50};
        ay = '{0, 0, 100, 200, 200, 100};
        reset_dut();
        send_object(150, 0);
        wait_valid(30, got, ins);
        exp = exp_q.pop_front();
        vectors++;
        if (!got || ins !== exp) begin
            $display("FAIL boundary: got valid=%b inside=%b want inside=%b", got, ins, exp); miscompares++;
        end
    endtask

    task automatic test_extreme();
        int obv [2] = '{1000, 0};
        int want [2] = '{1, 0};
        bit got, exp;
        logic ins;
        ax = '{0, 1023, 512, 0, 1023, 512};
        ay = '{512, 1023, 0, 1023, 0, 1023};
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            send_object(obv[t], obv[t]);
            wait_valid(30, got, ins);
            exp = exp_q.pop_front();
            vectors++;
            if (!got || ins !== exp || exp !== want[t][0]) begin
                $display("FAIL extreme_%0d: got valid=%b inside=%b want inside=%b", t, got, ins, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int bx [6] = '{100, 200, 250, 200, 100, 50};
        int by [6] = '{0, 0, 100, 200, 200, 100};
        int pulses = 0;
        reset_dut();
        fork
            begin
                int s, tx, ty, r, tmp, ox, oy;
                for (int o = 0; o < 50; o++) begin
                    if (o > 0) @(negedge clk);
                    s  = $urandom_range(1, 3);
                    tx = $urandom_range(0, 1023 - 250 * s);
                    ty = $urandom_range(0, 1023 - 200 * s);
                    for (int k = 0; k < 6; k++) begin
                        ax[k] = tx + s * bx[k];
                        ay[k] = ty + s * by[k];
                    end
                    for (int k = 5; k > 0; k--) begin
                        r = $urandom_range(0, k);
                        tmp = ax[k]; ax[k] = ax[r]; ax[r] = tmp;
                        tmp = ay[k]; ay[k] = ay[r]; ay[r] = tmp;
                    end
                    ox = tx + $urandom_range(0, 300 * s);
                    oy = ty + $urandom_range(0, 250 * s);
                    if (ox > 1023) ox = 1023;
                    if (oy > 1023) oy = 1023;
                    send_object(ox, oy);
                    repeat (17) begin
                        @(negedge clk);
                        X = TB_W'($urandom);
                        Y = TB_W'($urandom);
                    end
                end
            end
            begin
                bit exp;
                for (int n = 0; n < 50 * 24 + 40 && pulses < 50; n++) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        pulses++;
                        vectors++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_extra_pulse: got pulse %0d want none", pulses); miscompares++;
                        end else begin
                            exp = exp_q.pop_front();
                            if (is_inside !== exp) begin
                                $display("FAIL b2b_result %0d: got %b want %b", pulses, is_inside, exp);
                                miscompares++;
                            end
                        end
                    end
                end
            end
        join
        vectors++;
        if (pulses != 50) begin
            $display("FAIL b2b_pulse_count: got %0d want 50", pulses); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic ins = 1'b0;
        bit exp;
        ax = '{100, 200, 250, 200, 100, 50};
        ay = '{0, 0, 100, 200, 200, 100};
        reset_dut();
        send_object(300, 100);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_object(150, 100);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                pulses++;
                ins = is_inside;
            end
        end
        exp = exp_q.pop_front();
        vectors++;
        if (pulses != 1) begin
            $display("FAIL reset_mid_pulses: got %0d want 1", pulses); miscompares++;
        end
        vectors++;
        if (ins !== exp || exp !== 1'b1) begin
            $display("FAIL reset_mid_inside: got %b want %b", ins, exp); miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_ccw_latency();
        test_shuffled();
        test_boundary();
        test_extreme();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
